// File: rtl/inst_loader_pkg.sv
// Shared definitions for the boot-time instruction loader and the fetch-side BRAM.
package inst_loader_pkg;

  localparam int INST_ADDR_W    = 8;
  localparam int BYTES_PER_WORD = 4;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LEN  = 3'd1,
    ST_DATA = 3'd2,
    ST_CSUM = 3'd3,
    ST_DONE = 3'd4
  } loader_state_t;

endpackage

// File: rtl/inst_word_packer.sv
// Little-endian byte-to-word assembler with a running XOR checksum of every byte it packs.
module inst_word_packer
  import inst_loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clr_i,
  input  logic        strobe_i,
  input  logic [7:0]  byte_i,
  output logic [31:0] word_o,
  output logic        word_valid_o,
  output logic [7:0]  csum_o
);

  logic [1:0]  lane_q;
  logic [23:0] asm_q;
  logic [7:0]  acc_q;

  // Lanes 0..2 are held; lane 3 is taken straight from the input so the word completes on its handshake.
  always_ff @(posedge clk) begin
    if (rst || clr_i) begin
      lane_q <= 2'd0;
      asm_q  <= 24'd0;
      acc_q  <= 8'd0;
    end else if (strobe_i) begin
      lane_q <= lane_q + 2'd1;
      acc_q  <= acc_q ^ byte_i;
      case (lane_q)
        2'd0:    asm_q[7:0]   <= byte_i;
        2'd1:    asm_q[15:8]  <= byte_i;
        2'd2:    asm_q[23:16] <= byte_i;
        default: asm_q        <= asm_q;
      endcase
    end else begin
      lane_q <= lane_q;
      asm_q  <= asm_q;
      acc_q  <= acc_q;
    end
  end

  assign word_o       = {byte_i, asm_q};
  assign word_valid_o = strobe_i && (lane_q == 2'(BYTES_PER_WORD - 1));
  assign csum_o       = acc_q;

endmodule

// File: rtl/inst_loader.sv
// Framed byte-stream loader (length, LE words, XOR checksum) driving the instruction BRAM write port.
module inst_loader
  import inst_loader_pkg::*;
#(
  parameter int ADDR_W = INST_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              we,
  output logic [ADDR_W-1:0] waddr,
  output logic [31:0]       wdata,
  output logic              busy,
  output logic              done,
  output logic              err
);

  loader_state_t     state_q;
  logic [ADDR_W:0]   words_q;
  logic [ADDR_W:0]   idx_q;
  logic              in_ready_q;
  logic              we_q;
  logic [ADDR_W-1:0] waddr_q;
  logic [31:0]       wdata_q;
  logic              busy_q;
  logic              done_q;
  logic              err_q;

  logic              accept_s;
  logic              pack_clr_s;
  logic              pack_strobe_s;
  logic [31:0]       word_s;
  logic              word_valid_s;
  logic [7:0]        csum_s;
  logic [ADDR_W:0]   idx_next_s;

  assign accept_s      = in_valid && in_ready_q;
  assign pack_clr_s    = (state_q == ST_LEN) && accept_s;
  assign pack_strobe_s = (state_q == ST_DATA) && accept_s;
  assign idx_next_s    = idx_q + (ADDR_W+1)'(1);

  inst_word_packer u_packer (
    .clk          (clk),
    .rst          (rst),
    .clr_i        (pack_clr_s),
    .strobe_i     (pack_strobe_s),
    .byte_i       (in_data),
    .word_o       (word_s),
    .word_valid_o (word_valid_s),
    .csum_o       (csum_s)
  );

  // Session FSM with registered handshake, status and BRAM write port.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      words_q    <= '0;
      idx_q      <= '0;
      in_ready_q <= 1'b0;
      we_q       <= 1'b0;
      waddr_q    <= '0;
      wdata_q    <= 32'd0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      we_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            state_q    <= ST_LEN;
            in_ready_q <= 1'b1;
            busy_q     <= 1'b1;
          end
        end
        ST_LEN: begin
          if (accept_s) begin
            words_q <= (ADDR_W+1)'(in_data) + (ADDR_W+1)'(1);
            idx_q   <= '0;
            state_q <= ST_DATA;
          end
        end
        ST_DATA: begin
          // N <= 2**ADDR_W, so the extra index bit is only needed to recognise the final word.
          if (word_valid_s) begin
            we_q    <= 1'b1;
            waddr_q <= idx_q[ADDR_W-1:0];
            wdata_q <= word_s;
            idx_q   <= idx_next_s;
            if (idx_next_s == words_q) begin
              state_q <= ST_CSUM;
            end
          end
        end
        ST_CSUM: begin
          if (accept_s) begin
            state_q    <= ST_DONE;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b1;
            err_q      <= (in_data != csum_s);
          end
        end
        ST_DONE: begin
          if (start) begin
            state_q    <= ST_LEN;
            in_ready_q <= 1'b1;
            busy_q     <= 1'b1;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
          end
        end
        default: begin
          state_q    <= ST_IDLE;
          in_ready_q <= 1'b0;
          busy_q     <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready = in_ready_q;
  assign we       = we_q;
  assign waddr    = waddr_q;
  assign wdata    = wdata_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign err      = err_q;

endmodule
